// File: rtl/dac_pkg.sv
// ---------------------------------------------------------------------------
// dac_pkg
//  Shared definitions for the DAC write scheduler:
//   - scheduler FSM state encoding
//   - 16-bit DAC command word width and field offsets
//   - small elaboration-time helper used to size the shared counter
// ---------------------------------------------------------------------------
package dac_pkg;

  // Command word layout: {channel[1:0], ctrl[1:0], code[11:0]}
  localparam int DAC_CMD_W = 16;
  localparam int CH_LSB    = 14;
  localparam int CTRL_LSB  = 12;
  localparam int DATA_LSB  = 0;
  localparam int CH_W      = 2;
  localparam int CTRL_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_XFER      = 3'd3,
    ST_LDAC      = 3'd4,
    ST_GAP       = 3'd5
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//  Purely combinational round-robin picker. Searches req_i starting at
//  ptr_i and wrapping modulo N_CH; the first set bit wins.
//  Ports:
//   req_i   in  N_CH   request vector
//   ptr_i   in  IDX_W  highest-priority index for this search
//   grant_o out N_CH   one-hot winner (all zero if no request)
//   idx_o   out IDX_W  index of the winner
//   any_o   out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_CH-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int  cand;
    logic found;
    // NOTE: every output gets a default before the loop so no path through
    // the block leaves a variable unassigned, which would infer a latch.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N_CH; i++) begin
      cand = (int'(ptr_i) + i) % N_CH;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/dac_write_scheduler.sv
// ---------------------------------------------------------------------------
// dac_write_scheduler
//  Shares one 16-bit SPI DAC write master between N_CH requesters. Picks a
//  requester round-robin, latches the command word, pulses spi_start, waits
//  for the master's busy window, strobes ldac_n, then enforces an idle gap.
//  Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   req_valid    per-channel request, held until accepted
//   req_data     channel i code at [i*DATA_W +: DATA_W]
//   req_ready    one-hot single-cycle accept pulse
//   spi_start    single-cycle start pulse to the SPI master
//   spi_cmd      command word, held from one accept to the next
//   spi_busy     master busy (CS active)
//   ldac_n       DAC latch strobe, active low
//   sched_busy   high whenever the FSM is not idle
//   grant_ch     channel of the current / last transfer
//   timeout_err  sticky: master never went busy after a start
//   err_clr      clears timeout_err (a new timeout in the same cycle wins)
// ---------------------------------------------------------------------------
module dac_write_scheduler
  import dac_pkg::*;
#(
  parameter int          N_CH           = 4,
  parameter int          DATA_W         = 12,
  parameter logic [1:0]  CTRL_BITS      = 2'b11,
  parameter int          GAP_CYCLES     = 8,
  parameter int          LDAC_CYCLES    = 2,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req_valid,
  input  logic [N_CH*DATA_W-1:0] req_data,
  output logic [N_CH-1:0]        req_ready,
  output logic                   spi_start,
  output logic [DAC_CMD_W-1:0]   spi_cmd,
  input  logic                   spi_busy,
  output logic                   ldac_n,
  output logic                   sched_busy,
  output logic [CH_W-1:0]        grant_ch,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  // One counter is reused for the timeout, ldac width and gap phases.
  localparam int CNT_MAX = max3(TIMEOUT_CYCLES, GAP_CYCLES, LDAC_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // With no gap configured, the FSM returns straight to IDLE.
  function automatic state_e post_xfer_state();
    if (GAP_CYCLES > 0) return ST_GAP;
    return ST_IDLE;
  endfunction

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CH_W-1:0]        rr_ptr_q;
  logic [N_CH-1:0]        req_ready_q;
  logic                   spi_start_q;
  logic [DAC_CMD_W-1:0]   spi_cmd_q;
  logic                   ldac_n_q;
  logic [CH_W-1:0]        grant_ch_q;
  logic                   timeout_err_q;

  logic [N_CH-1:0]        arb_grant;
  logic [CH_W-1:0]        arb_idx;
  logic                   arb_any;
  logic [DATA_W-1:0]      arb_code;
  logic [DAC_CMD_W-1:0]   spi_cmd_d;
  logic [CH_W-1:0]        rr_ptr_d;
  logic                   timeout_hit;

  rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (CH_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    arb_code                         = req_data[arb_idx*DATA_W +: DATA_W];
    spi_cmd_d                        = '0;
    spi_cmd_d[CH_LSB   +: CH_W]      = arb_idx;
    spi_cmd_d[CTRL_LSB +: CTRL_W]    = CTRL_BITS;
    spi_cmd_d[DATA_LSB +: DATA_W]    = arb_code;
    // Next search starts just past the winner, so a channel that keeps
    // requesting cannot win twice while another channel is waiting.
    rr_ptr_d = (arb_idx == CH_W'(N_CH - 1)) ? '0 : arb_idx + 1'b1;
    timeout_hit = (state_q == ST_WAIT_BUSY) && !spi_busy && (cnt_q == TO_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      req_ready_q   <= '0;
      spi_start_q   <= 1'b0;
      spi_cmd_q     <= '0;
      ldac_n_q      <= 1'b1;
      grant_ch_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      req_ready_q <= '0;
      spi_start_q <= 1'b0;

      if (timeout_hit)  timeout_err_q <= 1'b1;
      else if (err_clr) timeout_err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            grant_ch_q  <= arb_idx;
            spi_cmd_q   <= spi_cmd_d;
            req_ready_q <= arb_grant;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= ST_START;
          end
        end
        ST_START: begin
          spi_start_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (spi_busy) begin
            state_q <= ST_XFER;
          end else if (timeout_hit) begin
            // Master never responded: skip the latch strobe entirely.
            cnt_q   <= '0;
            state_q <= post_xfer_state();
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_XFER: begin
          if (!spi_busy) begin
            ldac_n_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= ST_LDAC;
          end
        end
        ST_LDAC: begin
          if (cnt_q == LDAC_LAST) begin
            ldac_n_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= post_xfer_state();
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign spi_start   = spi_start_q;
  assign spi_cmd     = spi_cmd_q;
  assign ldac_n      = ldac_n_q;
  assign sched_busy  = (state_q != ST_IDLE);
  assign grant_ch    = grant_ch_q;
  assign timeout_err = timeout_err_q;

endmodule
